// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
// Package : sobel_pkg
// Desc    : Shared constants for the Sobel edge pipeline (luma weights, widths)
// Rev     : 1.0  initial release
// ============================================================================
package sobel_pkg;

  localparam int PIXEL_W_C        = 8;

  // Luma weights as 8-bit fractions of 256 (0.299, 0.587, 0.114)
  localparam int GRAY_COEF_R_C    = 77;
  localparam int GRAY_COEF_G_C    = 150;
  localparam int GRAY_COEF_B_C    = 29;
  localparam int GRAY_FRAC_BITS_C = 8;

endpackage : sobel_pkg
`default_nettype wire

// File: rtl/pipe_stage.sv
`default_nettype none
// ============================================================================
// Module : pipe_stage
// Desc   : Generic single-entry valid/ready register slice
// Rev    : 1.0  initial release
// ============================================================================
module pipe_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              w_accept;

  // Slot is free when empty or when its current beat leaves this edge
  assign ready_o  = ready_i | ~r_valid;
  assign w_accept = valid_i & ready_o;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= data_i;
    end else if (ready_o) begin
      r_valid <= 1'b0;
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;

endmodule : pipe_stage
`default_nettype wire

// File: rtl/rgb2gray.sv
`default_nettype none
// ============================================================================
// Module : rgb2gray
// Desc   : RGB to luma conversion, one registered stage with valid/ready
// Rev    : 1.0  initial release
// ============================================================================
module rgb2gray
  import sobel_pkg::*;
#(
  parameter int WIDTH_P = PIXEL_W_C
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [WIDTH_P-1:0] red_i,
  input  logic [WIDTH_P-1:0] green_i,
  input  logic [WIDTH_P-1:0] blue_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [WIDTH_P-1:0] gray_o
);

  localparam int SUM_W = WIDTH_P + 9;

  logic [SUM_W-1:0]   w_prod_r;
  logic [SUM_W-1:0]   w_prod_g;
  logic [SUM_W-1:0]   w_prod_b;
  logic [SUM_W-1:0]   w_sum;
  logic [SUM_W-1:0]   w_shift;
  logic [SUM_W-1:0]   w_max;
  logic [WIDTH_P-1:0] w_gray;

  assign w_prod_r = SUM_W'(GRAY_COEF_R_C) * SUM_W'(red_i);
  assign w_prod_g = SUM_W'(GRAY_COEF_G_C) * SUM_W'(green_i);
  assign w_prod_b = SUM_W'(GRAY_COEF_B_C) * SUM_W'(blue_i);
  assign w_sum    = w_prod_r + w_prod_g + w_prod_b;
  assign w_shift  = w_sum >> GRAY_FRAC_BITS_C;
  assign w_max    = {{(SUM_W-WIDTH_P){1'b0}}, {WIDTH_P{1'b1}}};

  // Weights total 256 so the clamp is unreachable; kept as a guard
  assign w_gray   = (w_shift > w_max) ? {WIDTH_P{1'b1}} : w_shift[WIDTH_P-1:0];

  pipe_stage #(
    .DATA_W (WIDTH_P)
  ) u_stage (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (w_gray),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (gray_o)
  );

endmodule : rgb2gray
`default_nettype wire

// File: tb/tb_rgb2gray.sv
`default_nettype none
// ============================================================================
// Module : tb_rgb2gray
// Desc   : Scoreboard bench for rgb2gray against a real-valued luma model
// Rev    : 1.0  initial release
// ============================================================================
module tb_rgb2gray;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [7:0] red_i = '0;
  logic [7:0] green_i = '0;
  logic [7:0] blue_i = '0;
  logic       valid_o;
  logic       ready_i = 1'b0;
  logic [7:0] gray_o;

  rgb2gray #(.WIDTH_P(8)) dut (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .red_i   (red_i),
    .green_i (green_i),
    .blue_i  (blue_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .gray_o  (gray_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int  exp;
    real y;
  } item_t;

  item_t q[$];
  int    total = 0;
  int    bad = 0;
  int    pushed = 0;
  int    popped = 0;
  real   sumsq = 0.0;
  int    maxerr = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference: exact fixed-point rule plus the real-valued luma
  function automatic item_t model(input int r, input int g, input int b);
    item_t it;
    int s;
    s = 77 * r + 150 * g + 29 * b;
    it.exp = s / 256;
    if (it.exp > 255) it.exp = 255;
    it.y = 0.299 * r + 0.587 * g + 0.114 * b;
    return it;
  endfunction

  task automatic drive(input bit v, input int r, input int g, input int b, input bit rdy);
    @(posedge clk_i);
    #1;
    valid_i = v;
    red_i   = 8'(r);
    green_i = 8'(g);
    blue_i  = 8'(b);
    ready_i = rdy;
    @(negedge clk_i);
    if (valid_i && ready_o) begin
      q.push_back(model(r, g, b));
      pushed++;
    end
  endtask

  // Monitor: the beat presented now is consumed at the next edge
  always @(negedge clk_i) begin
    if (rstn_i && valid_o && ready_i) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        item_t it;
        int fl, err;
        it = q.pop_front();
        popped++;
        chk("gray_value", int'(gray_o), it.exp);
        fl  = int'($floor(it.y));
        err = int'(gray_o) - fl;
        if (err < 0) err = -err;
        if (err > maxerr) maxerr = err;
        sumsq += (real'(gray_o) - it.y) * (real'(gray_o) - it.y);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   iter;
    int   run;
    logic [7:0] held;
    int   exp_b;
    item_t mb;
    real  rms;

    // Reset hold
    repeat (3) @(negedge clk_i);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_gray", int'(gray_o), 0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1);
      chk("idle_valid", int'(valid_o), 0);
      chk("idle_gray", int'(gray_o), 0);
    end

    // Directed single beats with one-cycle valid pulse
    begin
      int pr[5] = '{0, 255, 255, 0, 0};
      int pg[5] = '{0, 255, 0, 255, 0};
      int pb[5] = '{0, 255, 0, 0, 255};
      int pe[5] = '{0, 255, 76, 149, 28};
      for (int i = 0; i < 5; i++) begin
        drive(1, pr[i], pg[i], pb[i], 1);
        drive(0, 0, 0, 0, 1);
        chk("pulse_valid_hi", int'(valid_o), 1);
        chk("pulse_gray", int'(gray_o), pe[i]);
        drive(0, 0, 0, 0, 1);
        chk("pulse_valid_lo", int'(valid_o), 0);
        chk("pulse_gray_hold", int'(gray_o), pe[i]);
      end
    end

    // Random traffic with random backpressure until 1000 accepts
    begin
      int start;
      start = pushed;
      iter = 0;
      while ((pushed - start) < 1000 && iter < 20000) begin
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 255),
              $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 3) != 0);
        iter++;
      end
      chk("random_accepts", pushed - start, 1000);
    end
    repeat (3) drive(0, 0, 0, 0, 1);
    chk("drain_after_random", q.size(), 0);

    // Back-to-back burst
    run = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 1);
      if (i > 0 && valid_o) run++;
    end
    drive(0, 0, 0, 0, 1);
    if (valid_o) run++;
    drive(0, 0, 0, 0, 1);
    chk("burst_consecutive", run, 8);
    chk("burst_end_valid", int'(valid_o), 0);

    // Backpressure: A pending, B waits
    drive(1, 10, 200, 30, 0);
    held = gray_o;
    for (int i = 0; i < 5; i++) begin
      drive(1, 250, 40, 120, 0);
      if (i == 0) held = gray_o;
      chk("stall_ready", int'(ready_o), 0);
      chk("stall_valid", int'(valid_o), 1);
      chk("stall_gray", int'(gray_o), int'(held));
    end
    chk("stall_gray_a", int'(held), model(10, 200, 30).exp);
    drive(1, 250, 40, 120, 1);
    chk("release_ready", int'(ready_o), 1);
    drive(0, 0, 0, 0, 1);
    mb = model(250, 40, 120);
    exp_b = mb.exp;
    chk("release_next_valid", int'(valid_o), 1);
    chk("release_next_gray", int'(gray_o), exp_b);
    drive(0, 0, 0, 0, 1);

    // Async reset while a result is held
    drive(1, 200, 100, 50, 0);
    drive(0, 0, 0, 0, 0);
    chk("pre_areset_valid", int'(valid_o), 1);
    #2 rstn_i = 1'b0;
    #1;
    chk("areset_valid", int'(valid_o), 0);
    chk("areset_gray", int'(gray_o), 0);
    q.delete();
    @(negedge clk_i);
    rstn_i = 1'b1;
    drive(0, 0, 0, 0, 1);
    chk("post_areset_valid", int'(valid_o), 0);

    // Accuracy summary against real-valued luma
    chk("max_abs_err_le1", (maxerr <= 1) ? 1 : 0, 1);
    rms = (popped > 0) ? $sqrt(sumsq / popped) : 99.0;
    chk("rms_lt1", (rms < 1.0) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rgb2gray
`default_nettype wire
